block_scheduler: RTL and testbench
==================================

BLOCK_SCHEDULER -- requirements
Module: block_scheduler

Interface
REQ-001 SHALL have parameter NUM_BLOCKS, default 4: number of blocks per timestep, range 1..2^`DATA_WIDTH.
REQ-002 SHALL have parameter TIMEOUT, default 1024: maximum wait cycles per handshake before error.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  in  1  begin run; sampled only in IDLE.
REQ-006 SHALL have port abort  in  1  synchronous abort of a run.
REQ-007 SHALL have port num_steps  in  16  timesteps to run; latched when start is accepted.
REQ-008 SHALL have port swap_block  out  1  one-cycle request to the mmu to swap in block_index.
REQ-009 SHALL have port block_index  out  `DATA_WIDTH  index of the block being swapped or solved.
REQ-010 SHALL have port swap_done  in  1  mmu completion pulse.
REQ-011 SHALL have port solver_start  out  1  one-cycle LBMSolver start pulse.
REQ-012 SHALL have port solver_done  in  1  LBMSolver completion pulse.
REQ-013 SHALL have port mem_sel  out  1  ping-pong select between the f and f_n BRAM sets; toggles once per timestep.
REQ-014 SHALL have port step_count  out  16  completed timesteps in the current run.
REQ-015 SHALL have port busy  out  1  high in every state except IDLE.
REQ-016 SHALL have port done  out  1  one-cycle pulse on normal completion.
REQ-017 SHALL have port error  out  1  sticky timeout flag; cleared by the next accepted start.

Function
REQ-018 SHALL implement states IDLE, SWAP, WAIT_SWAP, SOLVE, WAIT_SOLVE; all outputs registered.
REQ-019 IDLE + start sampled at edge k: num_steps latched, step_count=0, block_index=0, error=0; if num_steps=0, done=1 for the cycle after edge k and state stays IDLE; otherwise state=WAIT_SWAP and swap_block=1 for exactly the cycle after edge k.
REQ-020 WAIT_SWAP + swap_done sampled at edge e: solver_start=1 for exactly the cycle after e; state=WAIT_SOLVE.
REQ-021 WAIT_SOLVE + solver_done at edge e, block_index<NUM_BLOCKS-1: block_index+1 and swap_block=1 in the cycle after e; state=WAIT_SWAP.
REQ-022 WAIT_SOLVE + solver_done at edge e, block_index=NUM_BLOCKS-1: at e+1 step_count+1, mem_sel inverted, block_index wraps to 0.
REQ-023 If the incremented step_count equals the latched num_steps, done=1 for the cycle after e, busy=0, state=IDLE; otherwise swap_block=1 for block 0 in the cycle after e, state=WAIT_SWAP.
REQ-024 swap_done outside WAIT_SWAP and solver_done outside WAIT_SOLVE SHALL be ignored; both high in the same cycle SHALL be processed for the current state only.
REQ-025 start while busy SHALL be ignored; num_steps changes after acceptance SHALL have no effect.
REQ-026 A wait counter SHALL clear on each entry to WAIT_SWAP/WAIT_SOLVE and increment each waiting cycle; on reaching TIMEOUT: error=1, state=IDLE, busy=0, no done.
REQ-027 abort sampled while busy: next edge state=IDLE, busy=0, no done, no further pulses; step_count, mem_sel and block_index hold; abort overrides a simultaneous done/swap_done/solver_done.
REQ-028 mem_sel SHALL persist across runs, so consecutive runs continue the ping-pong parity.
REQ-029 swap_block and solver_start SHALL never be high in the same cycle, and each SHALL never be high for two consecutive cycles.

Reset
REQ-030 rst low SHALL immediately force state=IDLE, swap_block=0, solver_start=0, done=0, busy=0, error=0, mem_sel=0, step_count=0, block_index=0, wait counter=0, latched num_steps=0, regardless of clock.
REQ-031 Deassertion of rst mid-run SHALL leave the block in IDLE, waiting for a new start.

Verification
REQ-032 NUM_BLOCKS=4, num_steps=2, mmu/solver respond 3 cycles after each request -> 8 swap_block pulses with block_index 0,1,2,3,0,1,2,3; 8 solver_start pulses; mem_sel 0->1->0; step_count ends 2; a single done.
REQ-033 num_steps=0, start -> done pulse 1 cycle later; no swap_block or solver_start; busy never high.
REQ-034 Start a run, then pulse start and pulse swap_done while in WAIT_SOLVE -> both ignored; pulse sequence identical to REQ-032.
REQ-035 TIMEOUT=16, withhold swap_done -> error=1 and busy=0 exactly 16 cycles after entering WAIT_SWAP; a new start clears error.
REQ-036 abort during WAIT_SOLVE of block 2, step 0 -> IDLE next edge; block_index=2, step_count=0 held; done never pulses.
REQ-037 rst low for 1 ns mid-cycle during WAIT_SWAP -> all outputs reach reset values before the next clock edge; a later solver_done has no effect.

Source files
------------

// File: rtl/block_scheduler.sv
// Timestep scheduler for a block-partitioned LBM solver: for each timestep it walks
// every block through an mmu swap then a solver run, flipping the f/f_n ping-pong select per step.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module block_scheduler #(
  parameter int NUM_BLOCKS = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [15:0]            num_steps,
  output logic                   swap_block,
  output logic [`DATA_WIDTH-1:0] block_index,
  input  logic                   swap_done,
  output logic                   solver_start,
  input  logic                   solver_done,
  output logic                   mem_sel,
  output logic [15:0]            step_count,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [2:0]             o_dbg_state
);

  localparam int IDX_W  = `DATA_WIDTH;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] SWAP       = 3'd1;
  localparam logic [2:0] WAIT_SWAP  = 3'd2;
  localparam logic [2:0] SOLVE      = 3'd3;
  localparam logic [2:0] WAIT_SOLVE = 3'd4;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_BLOCKS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  logic [2:0]        r_state;
  logic              r_swap_block;
  logic              r_solver_start;
  logic              r_done;
  logic              r_busy;
  logic              r_error;
  logic              r_mem_sel;
  logic [15:0]       r_step_count;
  logic [15:0]       r_steps;
  logic [IDX_W-1:0]  r_block_index;
  logic [WAIT_W-1:0] r_wait;
  logic [15:0]       w_step_next;

  assign w_step_next = r_step_count + 16'd1;

  // Handshake: swap_block / solver_start are single-cycle requests; the partner answers
  // later with a single-cycle swap_done / solver_done, honoured only in the matching wait state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_swap_block   <= 1'b0;
      r_solver_start <= 1'b0;
      r_done         <= 1'b0;
      r_busy         <= 1'b0;
      r_error        <= 1'b0;
      r_mem_sel      <= 1'b0;
      r_step_count   <= 16'd0;
      r_steps        <= 16'd0;
      r_block_index  <= '0;
      r_wait         <= '0;
    end else begin
      r_swap_block   <= 1'b0;
      r_solver_start <= 1'b0;
      r_done         <= 1'b0;
      if (r_state != IDLE && abort) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_steps       <= num_steps;
              r_step_count  <= 16'd0;
              r_block_index <= '0;
              r_error       <= 1'b0;
              r_wait        <= '0;
              if (num_steps == 16'd0) begin
                r_done <= 1'b1;
              end else begin
                r_state      <= WAIT_SWAP;
                r_busy       <= 1'b1;
                r_swap_block <= 1'b1;
              end
            end
          end
          WAIT_SWAP: begin
            if (swap_done) begin
              r_state        <= WAIT_SOLVE;
              r_solver_start <= 1'b1;
              r_wait         <= '0;
            end else if (r_wait == WAIT_LAST) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_error <= 1'b1;
            end else begin
              r_wait <= r_wait + 1'b1;
            end
          end
          WAIT_SOLVE: begin
            if (solver_done) begin
              r_wait <= '0;
              if (r_block_index != LAST_IDX) begin
                r_block_index <= r_block_index + 1'b1;
                r_swap_block  <= 1'b1;
                r_state       <= WAIT_SWAP;
              end else begin
                // Last block of the timestep: close the step and flip the BRAM set.
                r_block_index <= '0;
                r_step_count  <= w_step_next;
                r_mem_sel     <= ~r_mem_sel;
                if (w_step_next == r_steps) begin
                  r_done  <= 1'b1;
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                end else begin
                  r_swap_block <= 1'b1;
                  r_state      <= WAIT_SWAP;
                end
              end
            end else if (r_wait == WAIT_LAST) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_error <= 1'b1;
            end else begin
              r_wait <= r_wait + 1'b1;
            end
          end
          // The issue cycles of SWAP/SOLVE are carried by the registered request pulses,
          // so these encodings are never entered; recover to IDLE if ever seen.
          SWAP, SOLVE: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign swap_block   = r_swap_block;
  assign solver_start = r_solver_start;
  assign block_index  = r_block_index;
  assign mem_sel      = r_mem_sel;
  assign step_count   = r_step_count;
  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_block_scheduler.sv
// Directed bench for block_scheduler: a per-cycle vector table plus hand-written
// sequences for the full run, timeout, abort and asynchronous reset cases.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module tb_block_scheduler;

  logic                   clk;
  logic                   rst;
  logic                   start;
  logic                   abort;
  logic [15:0]            num_steps;
  logic                   swap_block;
  logic [`DATA_WIDTH-1:0] block_index;
  logic                   swap_done;
  logic                   solver_start;
  logic                   solver_done;
  logic                   mem_sel;
  logic [15:0]            step_count;
  logic                   busy;
  logic                   done;
  logic                   error;
  logic [2:0]             dbg_state;

  block_scheduler #(.NUM_BLOCKS(4), .TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .num_steps    (num_steps),
    .swap_block   (swap_block),
    .block_index  (block_index),
    .swap_done    (swap_done),
    .solver_start (solver_start),
    .solver_done  (solver_done),
    .mem_sel      (mem_sel),
    .step_count   (step_count),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .o_dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_miss = 0;
  logic [`DATA_WIDTH-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pack_exp(input logic [1:0] pulses, input logic [7:0] idx,
                                           input logic mem, input logic [15:0] step,
                                           input logic [2:0] flags);
    return {30'd0, pulses, 8'd0, idx, 3'd0, mem, step, 5'd0, flags};
  endfunction

  function automatic logic [63:0] pack_act();
    return {30'd0, swap_block, solver_start, 8'd0, 8'(block_index), 3'd0, mem_sel,
            step_count, 5'd0, busy, done, error};
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic s, input logic a, input logic [15:0] ns,
                       input logic sd, input logic sod);
    @(negedge clk);
    start = s; abort = a; num_steps = ns; swap_done = sd; solver_done = sod;
    @(posedge clk);
    #1;
  endtask

  // in_bits = {start, abort, swap_done, solver_done}; e_pulse = {swap_block, solver_start};
  // e_flags = {busy, done, error}
  typedef struct {
    logic [3:0]  in_bits;
    logic [15:0] ns;
    logic [1:0]  e_pulse;
    logic [7:0]  e_idx;
    logic        e_mem;
    logic [15:0] e_step;
    logic [2:0]  e_flags;
  } vec_t;

  vec_t vecs[17];

  // Full 2-step run against a responder answering 3 cycles after each request.
  task automatic run_nominal(input string tag, input bit inject, input logic exp_mem);
    int sw_t = 0, so_t = 0, sw_n = 0, so_n = 0, done_n = 0, toggles = 0;
    int cyc = 0, end_at = 300, end_step = 0;
    bit prev_sw = 0, prev_so = 0, viol = 0, injected = 0;
    logic last_mem;
    exp_q.delete();
    for (int st = 0; st < 2; st++)
      for (int b = 0; b < 4; b++) exp_q.push_back(`DATA_WIDTH'(b));
    @(negedge clk);
    start = 1'b1; num_steps = 16'd2; swap_done = 1'b0; solver_done = 1'b0; abort = 1'b0;
    last_mem = mem_sel;
    while (cyc < end_at) begin
      @(negedge clk);
      cyc++;
      start = 1'b0; swap_done = 1'b0; solver_done = 1'b0;
      if (swap_block && solver_start) viol = 1;
      if ((swap_block && prev_sw) || (solver_start && prev_so)) viol = 1;
      prev_sw = swap_block;
      prev_so = solver_start;
      if (mem_sel != last_mem) toggles++;
      last_mem = mem_sel;
      if (swap_block) begin
        sw_n++;
        sw_t = 3;
        if (exp_q.size() == 0) check({tag, "_extra_swap"}, 64'd1, 64'd0);
        else check({tag, "_swap_idx"}, 64'(block_index), 64'(exp_q.pop_front()));
      end
      if (solver_start) begin
        so_n++;
        so_t = 3;
      end
      if (done) begin
        done_n++;
        end_step = int'(step_count);
        if (end_at == 300) end_at = cyc + 4;
      end
      if (sw_t > 0) begin sw_t--; if (sw_t == 0) swap_done = 1'b1; end
      if (so_t > 0) begin so_t--; if (so_t == 0) solver_done = 1'b1; end
      if (inject && !injected && so_t == 1 && sw_t == 0) begin
        start = 1'b1; num_steps = 16'd7; swap_done = 1'b1; injected = 1;
      end
    end
    check({tag, "_swap_count"},  64'(sw_n), 64'd8);
    check({tag, "_solve_count"}, 64'(so_n), 64'd8);
    check({tag, "_done_count"},  64'(done_n), 64'd1);
    check({tag, "_done_step"},   64'(end_step), 64'd2);
    check({tag, "_step_end"},    64'(step_count), 64'd2);
    check({tag, "_mem_toggles"}, 64'(toggles), 64'd2);
    check({tag, "_mem_end"},     64'(mem_sel), 64'(exp_mem));
    check({tag, "_busy_end"},    64'(busy), 64'd0);
    check({tag, "_pulse_rules"}, 64'(viol), 64'd0);
    check({tag, "_idx_left"},    64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    int cnt;
    start = 0; abort = 0; num_steps = 0; swap_done = 0; solver_done = 0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("reset_state", pack_act(), pack_exp(2'b00, 8'd0, 1'b0, 16'd0, 3'b000));
    @(negedge clk);
    rst = 1'b1;

    vecs[0]  = '{4'b0000, 16'd0, 2'b00, 8'd0, 1'b0, 16'd0, 3'b000};
    vecs[1]  = '{4'b1000, 16'd1, 2'b10, 8'd0, 1'b0, 16'd0, 3'b100};
    vecs[2]  = '{4'b0000, 16'd1, 2'b00, 8'd0, 1'b0, 16'd0, 3'b100};
    vecs[3]  = '{4'b0010, 16'd1, 2'b01, 8'd0, 1'b0, 16'd0, 3'b100};
    vecs[4]  = '{4'b0011, 16'd1, 2'b10, 8'd1, 1'b0, 16'd0, 3'b100};
    vecs[5]  = '{4'b0010, 16'd1, 2'b01, 8'd1, 1'b0, 16'd0, 3'b100};
    vecs[6]  = '{4'b0001, 16'd1, 2'b10, 8'd2, 1'b0, 16'd0, 3'b100};
    vecs[7]  = '{4'b0010, 16'd1, 2'b01, 8'd2, 1'b0, 16'd0, 3'b100};
    vecs[8]  = '{4'b1001, 16'd5, 2'b10, 8'd3, 1'b0, 16'd0, 3'b100};
    vecs[9]  = '{4'b0011, 16'd5, 2'b01, 8'd3, 1'b0, 16'd0, 3'b100};
    vecs[10] = '{4'b0001, 16'd5, 2'b00, 8'd0, 1'b1, 16'd1, 3'b010};
    vecs[11] = '{4'b0000, 16'd5, 2'b00, 8'd0, 1'b1, 16'd1, 3'b000};
    vecs[12] = '{4'b1000, 16'd0, 2'b00, 8'd0, 1'b1, 16'd0, 3'b010};
    vecs[13] = '{4'b0011, 16'd0, 2'b00, 8'd0, 1'b1, 16'd0, 3'b000};
    vecs[14] = '{4'b1000, 16'd2, 2'b10, 8'd0, 1'b1, 16'd0, 3'b100};
    vecs[15] = '{4'b0010, 16'd2, 2'b01, 8'd0, 1'b1, 16'd0, 3'b100};
    vecs[16] = '{4'b0101, 16'd2, 2'b00, 8'd0, 1'b1, 16'd0, 3'b000};

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].in_bits[3], vecs[i].in_bits[2], vecs[i].ns,
            vecs[i].in_bits[1], vecs[i].in_bits[0]);
      check($sformatf("vec%0d", i), pack_act(),
            pack_exp(vecs[i].e_pulse, vecs[i].e_idx, vecs[i].e_mem, vecs[i].e_step,
                     vecs[i].e_flags));
    end

    // Full run; mem_sel enters at 1 and returns to 1 after two steps.
    run_nominal("run", 1'b0, 1'b1);
    run_nominal("inject", 1'b1, 1'b1);

    // Timeout with swap_done withheld.
    @(negedge clk);
    start = 1'b1; num_steps = 16'd1; swap_done = 1'b0; solver_done = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    cnt = 0;
    while (!error && cnt < 40) begin
      @(posedge clk);
      #1 cnt++;
      if (cnt == 15) check("timeout_busy_before", 64'(busy), 64'd1);
    end
    check("timeout_cycles", 64'(cnt), 64'd16);
    check("timeout_state", pack_act(), pack_exp(2'b00, 8'd0, 1'b1, 16'd0, 3'b001));
    drive(1'b0, 1'b0, 16'd1, 1'b1, 1'b1);
    check("error_sticky", pack_act(), pack_exp(2'b00, 8'd0, 1'b1, 16'd0, 3'b001));
    drive(1'b1, 1'b0, 16'd0, 1'b0, 1'b0);
    check("error_cleared", pack_act(), pack_exp(2'b00, 8'd0, 1'b1, 16'd0, 3'b010));

    // Abort in WAIT_SOLVE of block 2, step 0, together with solver_done.
    drive(1'b1, 1'b0, 16'd2, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 16'd2, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 16'd2, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 16'd2, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 16'd2, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 16'd2, 1'b1, 1'b0);
    check("pre_abort", pack_act(), pack_exp(2'b01, 8'd2, 1'b1, 16'd0, 3'b100));
    drive(1'b0, 1'b1, 16'd2, 1'b0, 1'b1);
    check("abort", pack_act(), pack_exp(2'b00, 8'd2, 1'b1, 16'd0, 3'b000));
    drive(1'b0, 1'b0, 16'd2, 1'b0, 1'b1);
    check("after_abort_solver", pack_act(), pack_exp(2'b00, 8'd2, 1'b1, 16'd0, 3'b000));
    drive(1'b0, 1'b0, 16'd2, 1'b1, 1'b0);
    check("after_abort_swap", pack_act(), pack_exp(2'b00, 8'd2, 1'b1, 16'd0, 3'b000));

    // Short asynchronous reset pulse mid-cycle while in WAIT_SWAP.
    drive(1'b1, 1'b0, 16'd2, 1'b0, 1'b0);
    start = 1'b0;
    check("pre_reset", pack_act(), pack_exp(2'b10, 8'd0, 1'b1, 16'd0, 3'b100));
    #1 rst = 1'b0;
    #1 check("async_reset", pack_act(), pack_exp(2'b00, 8'd0, 1'b0, 16'd0, 3'b000));
    rst = 1'b1;
    drive(1'b0, 1'b0, 16'd2, 1'b0, 1'b1);
    check("post_reset_solver", pack_act(), pack_exp(2'b00, 8'd0, 1'b0, 16'd0, 3'b000));
    drive(1'b0, 1'b0, 16'd2, 1'b1, 1'b0);
    check("post_reset_swap", pack_act(), pack_exp(2'b00, 8'd0, 1'b0, 16'd0, 3'b000));

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
